// File: rtl/alu_resp_serializer.sv
// Serializes one ALU result (4 DATA + 1 CTL packet) or error (1 CTL packet) descriptor onto sout.
// First start bit one cycle after accept; req_ready stays low for the whole frame, and requests made while busy are dropped.
module alu_resp_serializer #(
   parameter int BIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_err,
   input  logic [31:0] req_c,
   input  logic [3:0]  req_flags,
   input  logic [2:0]  req_err_flags,
   output logic        sout,
   output logic        busy
);

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, START, TYPE, DATA, STOP} state_t;

   state_t        state;
   logic [CW-1:0] cyc_cnt;
   logic [2:0]    bit_cnt;
   logic [2:0]    pkt_cnt;
   logic [2:0]    pkt_last;
   logic [31:0]   c_reg;
   logic [7:0]    ctl_reg;
   logic [7:0]    cur_byte;
   logic          cur_type;
   logic          adv;

   // CRC-3, x^3+x+1, init 0, MSB first
   function automatic logic [2:0] crc3(input logic [36:0] w);
      logic [2:0] crc;
      logic       fb;
      crc = 3'b000;
      for (int i = 36; i >= 0; i--) begin
         fb  = crc[2] ^ w[i];
         crc = {crc[1:0], 1'b0} ^ {1'b0, fb, fb};
      end
      return crc;
   endfunction

   // The final packet of every frame is the CTL packet
   always_comb begin
      cur_type = (pkt_cnt == pkt_last);
      cur_byte = ctl_reg;
      if (!cur_type) begin
         case (pkt_cnt)
            3'd0:    cur_byte = c_reg[31:24];
            3'd1:    cur_byte = c_reg[23:16];
            3'd2:    cur_byte = c_reg[15:8];
            3'd3:    cur_byte = c_reg[7:0];
            default: cur_byte = ctl_reg;
         endcase
      end
   end

   assign adv  = (cyc_cnt == CYC_LAST);
   assign busy = ~req_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         sout      <= 1'b1;
         req_ready <= 1'b1;
         cyc_cnt   <= '0;
         bit_cnt   <= '0;
         pkt_cnt   <= '0;
         pkt_last  <= '0;
         c_reg     <= '0;
         ctl_reg   <= '0;
      end else if (state == IDLE) begin
         if (req_valid && req_ready) begin
            state     <= START;
            sout      <= 1'b0;
            req_ready <= 1'b0;
            cyc_cnt   <= '0;
            bit_cnt   <= '0;
            pkt_cnt   <= '0;
            c_reg     <= req_c;
            if (req_err) begin
               pkt_last <= 3'd0;
               ctl_reg  <= {1'b1, req_err_flags, req_err_flags,
                            ^{1'b1, req_err_flags, req_err_flags}};
            end else begin
               pkt_last <= 3'd4;
               ctl_reg  <= {1'b0, req_flags, crc3({req_c, 1'b0, req_flags})};
            end
         end
      end else if (!adv) begin
         cyc_cnt <= cyc_cnt + 1'b1;
      end else begin
         cyc_cnt <= '0;
         case (state)
            START: begin
               state <= TYPE;
               sout  <= cur_type;
            end
            TYPE: begin
               state   <= DATA;
               bit_cnt <= 3'd7;
               sout    <= cur_byte[7];
            end
            DATA: begin
               if (bit_cnt == 3'd0) begin
                  state <= STOP;
                  sout  <= 1'b1;
               end else begin
                  bit_cnt <= bit_cnt - 3'd1;
                  sout    <= cur_byte[bit_cnt - 3'd1];
               end
            end
            STOP: begin
               if (cur_type) begin
                  state     <= IDLE;
                  req_ready <= 1'b1;
                  pkt_cnt   <= '0;
               end else begin
                  state   <= START;
                  pkt_cnt <= pkt_cnt + 3'd1;
                  sout    <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               sout      <= 1'b1;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule
